// File: rtl/rs_pkg.sv
// Shared widths and entry record for the reservation station.
package rs_pkg;
  localparam int DATA_W = 64;
  localparam int CMD_W  = 10;
  localparam int TAG_W  = 6;  // $clog2(32+1); must match ROBsizeLog of the station
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] val1;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] val2;
    logic [TAG_W-1:0]  destTag;
    logic [CMD_W-1:0]  cmds;
  } rs_entry_t;
endpackage

// File: rtl/rs_oldest_select.sv
// Oldest-ready picker: combinational, one-hot grant of the ready entry no other ready entry is older than.
module rs_oldest_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_ready,
  input  logic [N-1:0][N-1:0]  i_age,
  output logic [N-1:0]         o_grant,
  output logic                 o_valid
);
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = i_ready[i];
      for (int j = 0; j < N; j++) begin
        if (i_ready[j] && i_age[j][i]) o_grant[i] = 1'b0;
      end
    end
  end

  assign o_valid = |i_ready;
endmodule

// File: rtl/reservation_station.sv
// Reservation station: captures dispatches, snoops the CDB, issues the oldest ready entry.
// Issue outputs are combinational from state; stall_o is registered-state full, held by a non-accepting FU.
module reservation_station
  import rs_pkg::*;
#(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSentries  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  writeEn_i,
  input  logic [ROBsizeLog-1:0] robTag_i,
  input  logic [ROBsizeLog-1:0] robTag1_i,
  input  logic [ROBsizeLog-1:0] robTag2_i,
  input  logic [64:0]           robVal1_i,
  input  logic [64:0]           robVal2_i,
  input  logic [9:0]            commands_i,
  output logic                  stall_o,
  input  logic                  flush_i,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [63:0]           cdbData_i,
  output logic                  issueValid_o,
  input  logic                  issueReady_i,
  output logic [ROBsizeLog-1:0] issueTag_o,
  output logic [63:0]           issueVal1_o,
  output logic [63:0]           issueVal2_o,
  output logic [9:0]            issueCommands_o
);
  localparam int IDXW = $clog2(RSentries);

  rs_entry_t                          r_ent [RSentries];
  logic [RSentries-1:0][RSentries-1:0] r_age;

  logic [RSentries-1:0]                w_busy;
  logic [RSentries-1:0]                w_ready;
  logic [RSentries-1:0]                w_grant;
  logic                                w_any_ready;
  logic [IDXW-1:0]                     w_alloc_idx;
  logic                                w_alloc_found;
  logic                                w_wr;
  logic                                w_fire;
  rs_entry_t                           w_new_entry;
  logic [RSentries-1:0][RSentries-1:0] w_age_nxt;

  always_comb begin
    for (int i = 0; i < RSentries; i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy && (r_ent[i].tag1 == TAG_NONE) && (r_ent[i].tag2 == TAG_NONE);
    end
  end

  rs_oldest_select #(.N(RSentries)) u_sel (
    .i_ready (w_ready),
    .i_age   (r_age),
    .o_grant (w_grant),
    .o_valid (w_any_ready)
  );

  assign stall_o      = &w_busy;
  assign issueValid_o = w_any_ready;
  assign w_fire       = w_any_ready & issueReady_i;
  assign w_wr         = writeEn_i & ~stall_o;

  always_comb begin
    w_alloc_idx   = '0;
    w_alloc_found = 1'b0;
    for (int k = 0; k < RSentries; k++) begin
      if (!w_busy[k] && !w_alloc_found) begin
        w_alloc_idx   = IDXW'(k);
        w_alloc_found = 1'b1;
      end
    end
  end

  // A result on the CDB in the dispatch cycle would otherwise be missed forever.
  always_comb begin
    w_new_entry         = '0;
    w_new_entry.busy    = 1'b1;
    w_new_entry.destTag = robTag_i;
    w_new_entry.cmds    = commands_i;
    w_new_entry.tag1    = robTag1_i;
    w_new_entry.val1    = robVal1_i[63:0];
    w_new_entry.tag2    = robTag2_i;
    w_new_entry.val2    = robVal2_i[63:0];
    if (cdbValid_i && robTag1_i != TAG_NONE && cdbTag_i == robTag1_i) begin
      w_new_entry.tag1 = TAG_NONE;
      w_new_entry.val1 = cdbData_i;
    end
    if (cdbValid_i && robTag2_i != TAG_NONE && cdbTag_i == robTag2_i) begin
      w_new_entry.tag2 = TAG_NONE;
      w_new_entry.val2 = cdbData_i;
    end
  end

  always_comb begin
    w_age_nxt = r_age;
    for (int i = 0; i < RSentries; i++) begin
      for (int j = 0; j < RSentries; j++) begin
        if (w_fire && (w_grant[i] || w_grant[j])) w_age_nxt[i][j] = 1'b0;
        if (w_wr) begin
          if (IDXW'(i) == w_alloc_idx)      w_age_nxt[i][j] = 1'b0;
          else if (IDXW'(j) == w_alloc_idx) w_age_nxt[i][j] = w_busy[i] & ~(w_fire & w_grant[i]);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      for (int i = 0; i < RSentries; i++) r_ent[i] <= '0;
      r_age <= '0;
    end else begin
      for (int i = 0; i < RSentries; i++) begin
        if (r_ent[i].busy && r_ent[i].tag1 != TAG_NONE && cdbValid_i && r_ent[i].tag1 == cdbTag_i) begin
          r_ent[i].tag1 <= TAG_NONE;
          r_ent[i].val1 <= cdbData_i;
        end
        if (r_ent[i].busy && r_ent[i].tag2 != TAG_NONE && cdbValid_i && r_ent[i].tag2 == cdbTag_i) begin
          r_ent[i].tag2 <= TAG_NONE;
          r_ent[i].val2 <= cdbData_i;
        end
        if (w_fire && w_grant[i]) r_ent[i].busy <= 1'b0;
      end
      if (w_wr) r_ent[w_alloc_idx] <= w_new_entry;
      r_age <= w_age_nxt;
    end
  end

  always_comb begin
    issueTag_o      = '0;
    issueVal1_o     = '0;
    issueVal2_o     = '0;
    issueCommands_o = '0;
    for (int i = 0; i < RSentries; i++) begin
      if (w_grant[i]) begin
        issueTag_o      = issueTag_o      | r_ent[i].destTag;
        issueVal1_o     = issueVal1_o     | r_ent[i].val1;
        issueVal2_o     = issueVal2_o     | r_ent[i].val2;
        issueCommands_o = issueCommands_o | r_ent[i].cmds;
      end
    end
  end
endmodule
